// File: rtl/key_repeat_debouncer_if.sv
// key_repeat_debouncer_if
//   Button bus between the board inputs and the debouncer.
//   raw            : asynchronous button inputs, active high (master -> slave)
//   level          : debounced button state
//   press_pulse    : 1-cycle pulse on a debounced rising edge
//   release_pulse  : 1-cycle pulse on a debounced falling edge
//   repeat_pulse   : 1-cycle typematic pulse while a button is held
interface key_repeat_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] raw;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] repeat_pulse;

    modport master (
        output raw,
        input  level, press_pulse, release_pulse, repeat_pulse
    );

    modport slave (
        input  raw,
        output level, press_pulse, release_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_repeat_debouncer.sv
// key_repeat_debouncer
//   N-channel push-button conditioner: per-channel 2-FF synchroniser, one shared
//   sample prescaler, N-sample stability filter and typematic auto-repeat.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : key_repeat_debouncer_if.slave (raw in; level/press/release/repeat out)

// One button channel: sync, filter, edge detect, repeat FSM.
module key_repeat_debouncer_ch #(
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 8,
    parameter bit REP_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);
    localparam int CNT_W  = $clog2(STABLE_SAMPLES) + 1;
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W = $clog2(RMAX) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    logic              s1_q, s2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              level_q, level_d, level_dly_q;
    state_t            state_q;
    logic [RCNT_W-1:0] rcnt_q;
    logic              rep_q;
    logic              flip;

    // Level flips on the STABLE_SAMPLES-th consecutive disagreeing sample.
    assign flip    = tick_i && (s2_q != level_q) && (cnt_q == CNT_W'(STABLE_SAMPLES - 1));
    assign level_d = flip ? s2_q : level_q;

    assign level_o   = level_q;
    assign press_o   = level_q & ~level_dly_q;
    assign release_o = ~level_q & level_dly_q;
    assign repeat_o  = rep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            s1_q        <= raw_i;
            s2_q        <= s1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            if (tick_i) begin
                if (s2_q == level_q || flip) cnt_q <= '0;
                else                         cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // The FSM looks at the next level so that the tick which clears the
    // level cannot also emit a repeat (which would land on the release cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (!level_d) begin
                state_q <= S_IDLE;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (press_o && REP_EN) begin
                            state_q <= S_DELAY;
                            rcnt_q  <= '0;
                        end
                    end
                    S_DELAY: begin
                        if (tick_i) begin
                            if (rcnt_q == RCNT_W'(REPEAT_DELAY - 1)) begin
                                rep_q   <= 1'b1;
                                rcnt_q  <= '0;
                                state_q <= S_REPEAT;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    S_REPEAT: begin
                        if (tick_i) begin
                            if (rcnt_q == RCNT_W'(REPEAT_RATE - 1)) begin
                                rep_q  <= 1'b1;
                                rcnt_q <= '0;
                            end else begin
                                rcnt_q <= rcnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end
    end
endmodule

module key_repeat_debouncer #(
    parameter int              N_CH           = 4,
    parameter int              SAMPLE_DIV     = 12500,
    parameter int              STABLE_SAMPLES = 4,
    parameter int              REPEAT_DELAY   = 40,
    parameter int              REPEAT_RATE    = 8,
    parameter logic [N_CH-1:0] REPEAT_EN      = '1
) (
    input  logic                  clk,
    input  logic                  rst,
    key_repeat_debouncer_if.slave bus
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0] div_q;
    logic             tick;

    // Shared prescaler: one sample tick every SAMPLE_DIV cycles.
    assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_repeat_debouncer_ch #(
            .STABLE_SAMPLES (STABLE_SAMPLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .REP_EN         (REPEAT_EN[i])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .raw_i     (bus.raw[i]),
            .level_o   (bus.level[i]),
            .press_o   (bus.press_pulse[i]),
            .release_o (bus.release_pulse[i]),
            .repeat_o  (bus.repeat_pulse[i])
        );
    end
endmodule
